// File: rtl/rf_wb_arbiter_pkg.sv
// ============================================================================
// Module  : rf_pkg
// Brief   : Shared widths, constants and state encoding for rf_wb_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREG - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage

`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
// ============================================================================
// Module  : rf_wb_if
// Brief   : Writeback requester handshakes plus register-file write port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rf_wb_if;
    import rf_pkg::*;

    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // Arbiter side
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, rf_we, rf_waddr, rf_wdata
    );

    // Writeback stage / register file side
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

`default_nettype wire

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-input round-robin arbiter holding its own last-grant flop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic en,
    input  wire logic a_valid,
    input  wire logic b_valid,
    output logic      gnt_a,
    output logic      gnt_b,
    output logic      last_grant
);
    logic r_last;

    // On contention the requester not named by r_last wins.
    assign gnt_a = en && a_valid && (!b_valid ||  r_last);
    assign gnt_b = en && b_valid && (!a_valid || !r_last);
    assign last_grant = r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (gnt_a) begin
            r_last <= 1'b0;
        end else if (gnt_b) begin
            r_last <= 1'b1;
        end
    end
endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module  : rf_wb_arbiter
// Brief   : Clear sweep plus two-way arbitration onto the register-file port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter
    import rf_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst_n,
    input  wire logic  clr_req,
    output logic       init_done,
    output logic       last_grant,
    rf_wb_if.slave     bus
);
    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_arb_en;
    logic              w_gnt_a;
    logic              w_gnt_b;
    logic              w_sweep_done;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_issue;

    assign w_arb_en = (r_state == ST_RUN) && !clr_req;

    rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (w_arb_en),
        .a_valid    (bus.a_valid),
        .b_valid    (bus.b_valid),
        .gnt_a      (w_gnt_a),
        .gnt_b      (w_gnt_b),
        .last_grant (last_grant)
    );

    // The sweep ends once the r31 write is sitting in the output register,
    // so init_done rises the cycle after that write is presented.
    assign w_sweep_done = r_we && (r_waddr == LAST_REG);

    assign w_sel_addr = w_gnt_a ? bus.a_addr : bus.b_addr;
    assign w_sel_data = w_gnt_a ? bus.a_data : bus.b_data;
    assign w_issue    = (w_gnt_a || w_gnt_b) && (w_sel_addr != ZERO_REG);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: if (w_sweep_done) w_state_next = ST_RUN;
            ST_RUN:  if (clr_req)      w_state_next = ST_INIT;
            default:                   w_state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= ADDR_W'(1);
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (r_state == ST_INIT) begin
            if (w_sweep_done) begin
                r_we <= 1'b0;
            end else begin
                r_we    <= 1'b1;
                r_waddr <= r_cnt;
                r_wdata <= '0;
                if (r_cnt != LAST_REG) r_cnt <= r_cnt + 1'b1;
            end
        end else if (clr_req) begin
            r_cnt <= ADDR_W'(1);
            r_we  <= 1'b0;
        end else begin
            // Writes to r0 are consumed but leave the port idle.
            r_we <= w_issue;
            if (w_issue) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
        end
    end

    assign init_done    = (r_state == ST_RUN);
    assign bus.a_ready  = w_gnt_a;
    assign bus.b_ready  = w_gnt_b;
    assign bus.rf_we    = r_we;
    assign bus.rf_waddr = r_waddr;
    assign bus.rf_wdata = r_wdata;
endmodule

`default_nettype wire
